// File: rtl/ifd_decode_scoreboard_if.sv
// ---------------------------------------------------------------------------
// ifd_decode_scoreboard_if
// Snoop bus between the PDP-8 fetch/decode unit and its decode scoreboard.
//   stall           execution-unit stall (freezes the scoreboard delay line)
//   ifu_rd_req      fetch request, address/data valid in the same cycle
//   ifu_rd_addr     fetch address
//   ifu_rd_data     fetched instruction
//   base_addr       DUT decode: address of the decoded instruction
//   pdp_mem_opcode  DUT memory-reference decode {AND,TAD,ISZ,DCA,JMS,JMP,addr[8:0]}
//   pdp_op7_opcode  DUT group-7 decode, one-hot, MSB = NOP
// Modports: master drives the bus (IFD side / bench), slave snoops it.
// ---------------------------------------------------------------------------
interface ifd_decode_scoreboard_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
);
  logic              stall;
  logic              ifu_rd_req;
  logic [ADDR_W-1:0] ifu_rd_addr;
  logic [DATA_W-1:0] ifu_rd_data;
  logic [ADDR_W-1:0] base_addr;
  logic [14:0]       pdp_mem_opcode;
  logic [21:0]       pdp_op7_opcode;

  modport master (
    output stall, ifu_rd_req, ifu_rd_addr, ifu_rd_data,
    output base_addr, pdp_mem_opcode, pdp_op7_opcode
  );

  modport slave (
    input stall, ifu_rd_req, ifu_rd_addr, ifu_rd_data,
    input base_addr, pdp_mem_opcode, pdp_op7_opcode
  );
endinterface

// File: rtl/ifd_decode_scoreboard.sv
// ---------------------------------------------------------------------------
// ifd_decode_scoreboard
// Checks the PDP-8 fetch/decode unit against a built-in reference decode.
// Each accepted fetch (req && !stall) is classified (MEM / OP7 / SKIP) and
// travels through a LATENCY-stage delay line that freezes while stall=1.
// When the last stage retires, the DUT decode on the snoop bus is compared
// with the reference; results feed saturating counters, a one-cycle error
// strobe and first-error capture registers.
//
// Optional feature: define IFD_SB_OP7_EN to include group-7 decoding and the
// OP7 comparator. Without it every 7xxx instruction is classified SKIP and
// pdp_op7_opcode is ignored.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   sb (slave)          snoop bus, see ifd_decode_scoreboard_if
//   chk_err             one-cycle pulse on a mismatch
//   chk_err_kind        1 mem opcode, 2 op7 opcode, 3 base_addr; held
//   chk_cnt/err_cnt/skip_cnt  saturating statistics counters
//   first_err_valid/addr/data sticky capture of the first error
//   busy                any delay-line stage valid
// ---------------------------------------------------------------------------
module ifd_decode_scoreboard #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ifd_decode_scoreboard_if.slave sb,
  output logic                   chk_err,
  output logic [1:0]             chk_err_kind,
  output logic [CNT_W-1:0]       chk_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W-1:0]       skip_cnt,
  output logic                   first_err_valid,
  output logic [ADDR_W-1:0]      first_err_addr,
  output logic [DATA_W-1:0]      first_err_data,
  output logic                   busy
);

  typedef enum logic [1:0] {K_SKIP = 2'd0, K_MEM = 2'd1, K_OP7 = 2'd2} kind_e;

  // Delay line
  logic [LATENCY-1:0] v_q;
  logic [ADDR_W-1:0]  addr_q [LATENCY];
  logic [DATA_W-1:0]  data_q [LATENCY];
  kind_e              kind_q [LATENCY];
  logic [4:0]         idx_q  [LATENCY];

  // Result registers
  logic              chk_err_q;
  logic [1:0]        chk_err_kind_q;
  logic [CNT_W-1:0]  chk_cnt_q, err_cnt_q, skip_cnt_q;
  logic              first_err_valid_q;
  logic [ADDR_W-1:0] first_err_addr_q;
  logic [DATA_W-1:0] first_err_data_q;

  kind_e       in_kind_d;
  logic [4:0]  in_idx_d;
  logic        retire_s, mem_bad_s, op7_bad_s, base_bad_s, err_s;
  logic [1:0]  err_kind_s;
  logic [14:0] exp_mem_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

`ifdef IFD_SB_OP7_EN
  logic [5:0]  op7_hit_s;
  logic [21:0] exp_op7_s;

  // Returns {hit, one-hot index}; index 0 is NOP (vector MSB).
  function automatic logic [5:0] op7_lookup(input logic [11:0] ins);
    logic [5:0] r;
    case (ins)
      12'o7000: r = {1'b1, 5'd0};
      12'o7001: r = {1'b1, 5'd1};
      12'o7004: r = {1'b1, 5'd2};
      12'o7006: r = {1'b1, 5'd3};
      12'o7010: r = {1'b1, 5'd4};
      12'o7012: r = {1'b1, 5'd5};
      12'o7020: r = {1'b1, 5'd6};
      12'o7040: r = {1'b1, 5'd7};
      12'o7041: r = {1'b1, 5'd8};
      12'o7100: r = {1'b1, 5'd9};
      12'o7200: r = {1'b1, 5'd10};
      12'o7300: r = {1'b1, 5'd11};
      12'o7402: r = {1'b1, 5'd12};
      12'o7404: r = {1'b1, 5'd13};
      12'o7410: r = {1'b1, 5'd14};
      12'o7420: r = {1'b1, 5'd15};
      12'o7430: r = {1'b1, 5'd16};
      12'o7440: r = {1'b1, 5'd17};
      12'o7450: r = {1'b1, 5'd18};
      12'o7500: r = {1'b1, 5'd19};
      12'o7510: r = {1'b1, 5'd20};
      12'o7600: r = {1'b1, 5'd21};
      default:  r = 6'd0;
    endcase
    return r;
  endfunction

  assign op7_hit_s = op7_lookup(sb.ifu_rd_data[11:0]);
`else
  logic unused_op7_s;
  assign unused_op7_s = ^{sb.pdp_op7_opcode, idx_q[LATENCY-1]};
`endif

  // Classify the fetch at accept time.
  always_comb begin
    in_kind_d = K_SKIP;
    in_idx_d  = 5'd0;
    if (sb.ifu_rd_data[11:9] <= 3'd5) begin
      in_kind_d = K_MEM;
    end
`ifdef IFD_SB_OP7_EN
    else if (op7_hit_s[5]) begin
      in_kind_d = K_OP7;
      in_idx_d  = op7_hit_s[4:0];
    end
`endif
    else begin
      in_kind_d = K_SKIP;
    end
  end

  // Compare the retiring entry against the DUT decode.
  always_comb begin
    retire_s   = v_q[LATENCY-1] && !sb.stall;
    // AND (opcode 0) sits at flag bit 5, so shift a 1 down from the top.
    exp_mem_s  = {6'b100000 >> data_q[LATENCY-1][11:9], data_q[LATENCY-1][8:0]};
    mem_bad_s  = (kind_q[LATENCY-1] == K_MEM) && (sb.pdp_mem_opcode != exp_mem_s);
`ifdef IFD_SB_OP7_EN
    exp_op7_s  = 22'h200000 >> idx_q[LATENCY-1];
    op7_bad_s  = (kind_q[LATENCY-1] == K_OP7) && (sb.pdp_op7_opcode != exp_op7_s);
`else
    op7_bad_s  = 1'b0;
`endif
    base_bad_s = (kind_q[LATENCY-1] != K_SKIP) && (sb.base_addr != addr_q[LATENCY-1]);
    err_s      = retire_s && (mem_bad_s || op7_bad_s || base_bad_s);
    if (mem_bad_s) begin
      err_kind_s = 2'd1;
    end else if (op7_bad_s) begin
      err_kind_s = 2'd2;
    end else begin
      err_kind_s = 2'd3;
    end
  end

  // Stall-aware delay line: shift everything when not stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        kind_q[i] <= K_SKIP;
        idx_q[i]  <= 5'd0;
      end
    end else if (!sb.stall) begin
      v_q[0]    <= sb.ifu_rd_req;
      addr_q[0] <= sb.ifu_rd_addr;
      data_q[0] <= sb.ifu_rd_data;
      kind_q[0] <= in_kind_d;
      idx_q[0]  <= in_idx_d;
      for (int i = 1; i < LATENCY; i++) begin
        v_q[i]    <= v_q[i-1];
        addr_q[i] <= addr_q[i-1];
        data_q[i] <= data_q[i-1];
        kind_q[i] <= kind_q[i-1];
        idx_q[i]  <= idx_q[i-1];
      end
    end
  end

  // Result strobe, counters and first-error capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_err_q         <= 1'b0;
      chk_err_kind_q    <= 2'd0;
      chk_cnt_q         <= '0;
      err_cnt_q         <= '0;
      skip_cnt_q        <= '0;
      first_err_valid_q <= 1'b0;
      first_err_addr_q  <= '0;
      first_err_data_q  <= '0;
    end else begin
      chk_err_q <= err_s;
      if (retire_s && (kind_q[LATENCY-1] != K_SKIP)) chk_cnt_q <= sat_inc(chk_cnt_q);
      if (retire_s && (kind_q[LATENCY-1] == K_SKIP)) skip_cnt_q <= sat_inc(skip_cnt_q);
      if (err_s) begin
        chk_err_kind_q <= err_kind_s;
        err_cnt_q      <= sat_inc(err_cnt_q);
        if (!first_err_valid_q) begin
          first_err_valid_q <= 1'b1;
          first_err_addr_q  <= addr_q[LATENCY-1];
          first_err_data_q  <= data_q[LATENCY-1];
        end
      end
    end
  end

  assign chk_err         = chk_err_q;
  assign chk_err_kind    = chk_err_kind_q;
  assign chk_cnt         = chk_cnt_q;
  assign err_cnt         = err_cnt_q;
  assign skip_cnt        = skip_cnt_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_addr  = first_err_addr_q;
  assign first_err_data  = first_err_data_q;
  assign busy            = |v_q;

endmodule

// File: tb/tb_ifd_decode_scoreboard.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ifd_decode_scoreboard. A queue-based model tracks
// accepted fetches by the number of unstalled edges left before retirement
// and predicts every output; directed cases pin the model with literals.
// ---------------------------------------------------------------------------
module tb_ifd_decode_scoreboard;
  localparam int AW   = 12;
  localparam int DW   = 12;
  localparam int LAT  = 3;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ifd_decode_scoreboard_if #(.ADDR_W(AW), .DATA_W(DW)) sb_if ();

  logic          chk_err;
  logic [1:0]    chk_err_kind;
  logic [CW-1:0] chk_cnt, err_cnt, skip_cnt;
  logic          first_err_valid;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;
  logic          busy;

  ifd_decode_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .sb(sb_if.slave),
    .chk_err(chk_err), .chk_err_kind(chk_err_kind),
    .chk_cnt(chk_cnt), .err_cnt(err_cnt), .skip_cnt(skip_cnt),
    .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
    .first_err_data(first_err_data), .busy(busy)
  );

  typedef struct {
    logic [11:0] addr;
    logic [11:0] data;
    int          kind;   // 0 skip, 1 mem, 2 op7
    int          idx;
    int          left;   // unstalled edges until retirement
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int failures = 0;

  logic        m_err;
  int          m_kind, m_chk, m_errc, m_skip;
  logic        m_fv;
  logic [11:0] m_fa, m_fd;

  logic [11:0] op7_codes [22] = '{
    12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012, 12'o7020, 12'o7040,
    12'o7041, 12'o7100, 12'o7200, 12'o7300, 12'o7402, 12'o7404, 12'o7410, 12'o7420,
    12'o7430, 12'o7440, 12'o7450, 12'o7500, 12'o7510, 12'o7600};

  function automatic void classify(input logic [11:0] d, output int kind, output int idx);
    kind = 0;
    idx  = 0;
    if (d[11:9] <= 3'd5) kind = 1;
`ifdef IFD_SB_OP7_EN
    else for (int i = 0; i < 22; i++) if (op7_codes[i] == d) begin kind = 2; idx = i; end
`endif
  endfunction

  function automatic logic [14:0] exp_mem(input logic [11:0] d);
    logic [14:0] v;
    int op;
    v = 15'd0;
    op = int'(d[11:9]);
    v[14 - op] = 1'b1;
    v[8:0] = d[8:0];
    return v;
  endfunction

  function automatic logic [21:0] exp_op7(input int idx);
    logic [21:0] v;
    v = 22'd0;
    v[21 - idx] = 1'b1;
    return v;
  endfunction

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  function automatic logic [11:0] rnd_ins();
    int s;
    s = $urandom_range(9, 0);
    if (s < 4)      return {3'($urandom_range(5, 0)), 9'($urandom)};
    else if (s < 7) return op7_codes[$urandom_range(21, 0)];
    else if (s < 8) return {3'd7, 9'($urandom)};
    else            return {3'd6, 9'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("chk_err", 32'(chk_err), 32'(m_err));
    chk("chk_err_kind", 32'(chk_err_kind), 32'(m_kind));
    chk("chk_cnt", 32'(chk_cnt), 32'(m_chk));
    chk("err_cnt", 32'(err_cnt), 32'(m_errc));
    chk("skip_cnt", 32'(skip_cnt), 32'(m_skip));
    chk("first_err_valid", 32'(first_err_valid), 32'(m_fv));
    chk("first_err_addr", 32'(first_err_addr), 32'(m_fa));
    chk("first_err_data", 32'(first_err_data), 32'(m_fd));
    chk("busy", 32'(busy), 32'(q.size() != 0));
  endtask

  // One clock: drive at the current negedge, predict the coming edge,
  // compare at the following negedge. corrupt: 0 none, 1 flip opcode bit,
  // 2 base_addr+1, 3 drive CMA on op7 bus, 4 drive TAD 234 literal on mem bus.
  task automatic cycle(input bit req, input logic [11:0] a, input logic [11:0] d,
                       input bit stl, input int corrupt);
    logic [14:0] mv;
    logic [21:0] ov;
    logic [11:0] ba;
    ent_t        e;
    int          k, ix;
    bit          opbad, basebad;
    sb_if.stall       = stl;
    sb_if.ifu_rd_req  = req;
    sb_if.ifu_rd_addr = a;
    sb_if.ifu_rd_data = d;
    if (q.size() > 0 && q[0].left == 1) begin
      ba = q[0].addr;
      mv = exp_mem(q[0].data);
      ov = (q[0].kind == 2) ? exp_op7(q[0].idx) : 22'd0;
      case (corrupt)
        1: begin
          mv = mv ^ (15'd1 << $urandom_range(14, 0));
          ov = ov ^ (22'd1 << $urandom_range(21, 0));
        end
        2: ba = ba + 12'd1;
        3: ov = 22'h004000;
        4: mv = {6'b010000, 9'o234};
        default: ;
      endcase
    end else begin
      mv = 15'($urandom);
      ov = 22'($urandom);
      ba = 12'($urandom);
    end
    sb_if.base_addr      = ba;
    sb_if.pdp_mem_opcode = mv;
    sb_if.pdp_op7_opcode = ov;

    m_err = 1'b0;
    if (!stl) begin
      foreach (q[i]) q[i].left--;
      if (q.size() > 0 && q[0].left == 0) begin
        e = q.pop_front();
        if (e.kind == 0) begin
          m_skip = sat(m_skip);
        end else begin
          m_chk   = sat(m_chk);
          opbad   = (e.kind == 1) ? (mv != exp_mem(e.data)) : (ov != exp_op7(e.idx));
          basebad = (ba != e.addr);
          if (opbad || basebad) begin
            m_err  = 1'b1;
            m_kind = opbad ? e.kind : 3;
            m_errc = sat(m_errc);
            if (!m_fv) begin
              m_fv = 1'b1;
              m_fa = e.addr;
              m_fd = e.data;
            end
          end
        end
      end
      if (req) begin
        classify(d, k, ix);
        q.push_back('{addr: a, data: d, kind: k, idx: ix, left: LAT});
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input int corrupt);
    for (int i = 0; i < n; i++) cycle(1'b0, 12'd0, 12'd0, 1'b0, corrupt);
  endtask

  task automatic model_clear();
    q.delete();
    m_err = 1'b0; m_kind = 0; m_chk = 0; m_errc = 0; m_skip = 0;
    m_fv = 1'b0; m_fa = 12'd0; m_fd = 12'd0;
  endtask

  // Called at a negedge; reset takes effect asynchronously.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_clear();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_chk_cnt", 32'(chk_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_skip_cnt", 32'(skip_cnt), 32'd0);
    chk("rst_chk_err", 32'(chk_err), 32'd0);
    chk("rst_first_err_valid", 32'(first_err_valid), 32'd0);
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;
  endtask

  initial begin
    sb_if.stall = 1'b0; sb_if.ifu_rd_req = 1'b0; sb_if.ifu_rd_addr = '0;
    sb_if.ifu_rd_data = '0; sb_if.base_addr = '0;
    sb_if.pdp_mem_opcode = '0; sb_if.pdp_op7_opcode = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // TAD 1234 at 0200, DUT decode given as a literal
    cycle(1'b1, 12'o0200, 12'o1234, 1'b0, 0);
    idle(2, 0);
    idle(1, 4);
    chk("t1_chk_cnt", 32'(chk_cnt), 32'd1);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);
    chk("t1_chk_err", 32'(chk_err), 32'd0);

    // 0055 with four stalled cycles after accept: retires at accept+7
    cycle(1'b1, 12'o0210, 12'o0055, 1'b0, 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 12'd0, 12'd0, 1'b1, 0);
    idle(2, 0);
    chk("t2_chk_cnt_before", 32'(chk_cnt), 32'd1);
    idle(1, 0);
    chk("t2_chk_cnt_at", 32'(chk_cnt), 32'd2);
    chk("t2_err_cnt", 32'(err_cnt), 32'd0);

`ifdef IFD_SB_OP7_EN
    // CIA fetched, DUT reports CMA
    cycle(1'b1, 12'o0400, 12'o7041, 1'b0, 0);
    idle(2, 0);
    idle(1, 3);
    chk("t3_chk_err", 32'(chk_err), 32'd1);
    chk("t3_kind", 32'(chk_err_kind), 32'd2);
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);
    chk("t3_first_data", 32'(first_err_data), 32'o7041);
    chk("t3_first_addr", 32'(first_err_addr), 32'o0400);
`endif

    // JMP 5100 at 0300 with base_addr 0301
    cycle(1'b1, 12'o0300, 12'o5100, 1'b0, 0);
    idle(2, 0);
    idle(1, 2);
    chk("t4_chk_err", 32'(chk_err), 32'd1);
    chk("t4_kind", 32'(chk_err_kind), 32'd3);
`ifdef IFD_SB_OP7_EN
    chk("t4_err_cnt", 32'(err_cnt), 32'd2);
    chk("t4_first_data", 32'(first_err_data), 32'o7041);
    chk("t4_chk_cnt", 32'(chk_cnt), 32'd4);
`else
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);
    chk("t4_first_data", 32'(first_err_data), 32'o5100);
    chk("t4_chk_cnt", 32'(chk_cnt), 32'd3);
`endif

    // IOT is skipped
    cycle(1'b1, 12'o0310, 12'o6001, 1'b0, 0);
    idle(3, 0);
    chk("t5_skip_cnt", 32'(skip_cnt), 32'd1);
`ifdef IFD_SB_OP7_EN
    chk("t5_chk_cnt", 32'(chk_cnt), 32'd4);
`else
    chk("t5_chk_cnt", 32'(chk_cnt), 32'd3);
    // without group-7 decoding, IAC is skipped
    cycle(1'b1, 12'o0320, 12'o7001, 1'b0, 0);
    idle(3, 0);
    chk("t6_skip_cnt", 32'(skip_cnt), 32'd2);
    chk("t6_chk_cnt", 32'(chk_cnt), 32'd3);
`endif

    // Randomised traffic: stalls, back-to-back fetches, occasional faults;
    // long enough for the narrow counters to saturate.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(9, 0);
      cycle(($urandom_range(9, 0) < 7), 12'($urandom), rnd_ins(),
            ($urandom_range(4, 0) == 0), (r == 0) ? 1 : ((r == 1) ? 2 : 0));
    end
    idle(LAT, 0);
    chk("sat_chk_cnt", 32'(chk_cnt), MAXC);

    // Back-to-back stream interrupted by reset
    for (int i = 0; i < 10; i++) cycle(1'b1, 12'($urandom), rnd_ins(), 1'b0, 0);
    do_reset();
    for (int i = 0; i < 30; i++)
      cycle(($urandom_range(1, 0) == 1), 12'($urandom), rnd_ins(), ($urandom_range(3, 0) == 0), 0);
    idle(LAT + 1, 0);
    chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("post_rst_first_valid", 32'(first_err_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
